keypad_scanner: RTL
===================

# keypad_scanner

Parametrised matrix-keypad scanner for the calculator front end: drives one-hot columns, samples synchronised rows, debounces over whole scan frames and hands a binary key code to the main FSM with a valid/ack handshake. Successor to the fixed 4x4 keyboard controller: generic matrix size, scan rate and debounce depth, plus multi-key rejection and overrun reporting.

## Interface
- NCOLS, 4: column drive lines (2..8).
- NROWS, 4: row sense lines (2..8).
- SCAN_DIV, 16: clock cycles per column slot (>= 4).
- DEBOUNCE, 4: consecutive identical frames needed for press and release (1..15).
- KEYW, $clog2(NROWS*NCOLS): key code width (derived, not overridden).
- CLK  in  1  single system clock.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  scan enable.
- COL  out  NCOLS  one-hot column drive, active high.
- ROW  in  NROWS  row sense, active high, asynchronous to CLK.
- KEY_CODE  out  KEYW  code = row*NCOLS + col of accepted key.
- KEY_VALID  out  1  key pending; held until acknowledged.
- KEY_ACK  in  1  consumer acknowledge.
- MULTI  out  1  one-cycle pulse: frame with >1 contact.
- OVERRUN  out  1  one-cycle pulse: new key accepted while KEY_VALID still high.

## Operation
- ROW passes a 2-flop synchroniser before use.
- Column index c advances every SCAN_DIV cycles, wraps NCOLS-1 -> 0; COL = 1<<c. Rows sampled on the last cycle of each slot.
- Frame = NCOLS slots. Frame summary at frame end: count of contacts (saturating at 2) and lowest code among them.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB.
  - IDLE: single-contact frame -> PRESS_DB, db_cnt=1, cand=code.
  - PRESS_DB: same single code -> db_cnt++; reaching DEBOUNCE -> accept, go HELD. Different code, empty or multi frame -> IDLE, db_cnt=0.
  - HELD: empty frame -> REL_DB, db_cnt=1; any non-empty frame stays HELD (no repeat).
  - REL_DB: empty -> db_cnt++; reaching DEBOUNCE -> IDLE. Non-empty -> HELD.
- DEBOUNCE=1: accept/release directly from IDLE/HELD on the first qualifying frame.
- Accept: if KEY_VALID=0, load KEY_CODE=cand, set KEY_VALID. If KEY_VALID=1, KEY_CODE unchanged, OVERRUN pulses, key dropped (still goes HELD).
- KEY_ACK with KEY_VALID=1 clears KEY_VALID next cycle; KEY_ACK while invalid ignored. Accept and ACK in same cycle: ACK clears the old key first, new key loads, no OVERRUN.
- MULTI pulses at each frame end whose count >= 2, in any state.
- EN=0: COL=0, slot counter, column index, db_cnt cleared, state IDLE; KEY_VALID/KEY_CODE retained, ACK still honoured. Scanning restarts at column 0 the cycle EN returns high.

## Timing
- Reset values: COL=0, KEY_CODE=0, KEY_VALID=0, MULTI=0, OVERRUN=0, state IDLE, all counters 0.
- First cycle after RESET deasserts with EN=1: COL=1 (col 0).
- Frame length NCOLS*SCAN_DIV cycles; row sample lag through synchroniser 2 cycles, covered by SCAN_DIV >= 4.
- KEY_VALID, MULTI, OVERRUN all registered; rise the cycle after the frame-end sample.
- Press latency from a clean press stable before frame start: DEBOUNCE frames + 1 cycle.
- RESET mid-frame or mid-handshake: everything returns to reset values next cycle; pending key lost.

## Structure
- kbd_pkg: state enum (IDLE, PRESS_DB, HELD, REL_DB), contact-count encoding (NONE, ONE, MANY), clog2 helper.
- Sub-module keypad_col_scan: slot counter, column driver, synchroniser and frame summariser (outputs frame_done, count, code). Top holds FSM, debounce counter and handshake.

## Test plan
- 4x4, SCAN_DIV=4, DEBOUNCE=4: hold row 2/col 1 -> KEY_VALID rises after 4 frames (64 cycles + sync), KEY_CODE=9; ACK -> VALID low next cycle.
- Bounce: contact toggled every 2nd frame for 10 frames -> no KEY_VALID; stable afterwards -> accepted once.
- Rows 0 and 3 pressed in col 2 -> MULTI pulses each frame, KEY_VALID stays 0.
- Press/release/press code 5 then code 12 without ACK -> KEY_CODE=5, one OVERRUN pulse.
- Accept coincident with KEY_ACK on pending key -> new code loaded, VALID stays 1, no OVERRUN.
- EN dropped mid-PRESS_DB, RESET mid-HELD -> COL=0, counters cleared; after reset all outputs 0, COL=1 first cycle.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } kbd_state_t;

  // Per-frame contact count, saturating at MANY.
  typedef enum logic [1:0] {
    NONE,
    ONE,
    MANY
  } contact_cnt_t;

  localparam int DBW = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column driver, row synchroniser and per-frame contact summariser.
module keypad_col_scan import kbd_pkg::*; #(
  parameter int NCOLS    = 4,
  parameter int NROWS    = 4,
  parameter int SCAN_DIV = 16,
  localparam int KEYW    = clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NROWS-1:0] row,
  output logic [NCOLS-1:0] col,
  output logic             frame_done,
  output logic [1:0]       count,
  output logic [KEYW-1:0]  code
);

  localparam int SLOTW = clog2(SCAN_DIV);
  localparam int COLW  = clog2(NCOLS);

  logic [SLOTW-1:0] slot_cnt;
  logic [COLW-1:0]  col_idx;
  logic [NROWS-1:0] row_meta;
  logic [NROWS-1:0] row_sync;
  contact_cnt_t     acc_count;
  logic [KEYW-1:0]  acc_code;
  contact_cnt_t     slot_count;
  logic [KEYW-1:0]  slot_code;
  contact_cnt_t     merged_count;
  logic [KEYW-1:0]  merged_code;
  logic             sample;
  logic             last_col;

  assign sample     = en && (slot_cnt == SLOTW'(SCAN_DIV - 1));
  assign last_col   = (col_idx == COLW'(NCOLS - 1));
  assign col        = (en && !reset) ? (NCOLS'(1) << col_idx) : '0;
  assign frame_done = sample && last_col;
  assign count      = merged_count;
  assign code       = merged_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Descending scan leaves the lowest contacting row as the slot code.
  always_comb begin
    slot_count = NONE;
    slot_code  = '0;
    for (int r = NROWS - 1; r >= 0; r--) begin
      if (row_sync[r]) begin
        slot_count = (slot_count == NONE) ? ONE : MANY;
        slot_code  = KEYW'(r * NCOLS) + KEYW'(col_idx);
      end
    end
  end

  always_comb begin
    merged_count = acc_count;
    merged_code  = acc_code;
    if (slot_count != NONE) begin
      if (acc_count == NONE) begin
        merged_count = slot_count;
        merged_code  = slot_code;
      end else begin
        merged_count = MANY;
        if (slot_code < acc_code) begin
          merged_code = slot_code;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      slot_cnt  <= '0;
      col_idx   <= '0;
      acc_count <= NONE;
      acc_code  <= '0;
    end else if (sample) begin
      slot_cnt <= '0;
      if (last_col) begin
        col_idx   <= '0;
        acc_count <= NONE;
        acc_code  <= '0;
      end else begin
        col_idx   <= col_idx + COLW'(1);
        acc_count <= merged_count;
        acc_code  <= merged_code;
      end
    end else begin
      slot_cnt <= slot_cnt + SLOTW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: frame-level debounce FSM and valid/ack key handoff.
module keypad_scanner import kbd_pkg::*; #(
  parameter int NCOLS    = 4,
  parameter int NROWS    = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4,
  localparam int KEYW    = clog2(NROWS * NCOLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [NCOLS-1:0] col,
  input  logic [NROWS-1:0] row,
  output logic [KEYW-1:0]  key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             multi,
  output logic             overrun
);

  kbd_state_t      state;
  kbd_state_t      state_next;
  logic [DBW-1:0]  db_cnt;
  logic [DBW-1:0]  db_next;
  logic [KEYW-1:0] cand;
  logic [KEYW-1:0] cand_next;
  logic            accept;
  logic            frame_done;
  logic [1:0]      frame_count;
  logic [KEYW-1:0] frame_code;
  contact_cnt_t    frame_cnt_e;
  logic            single;
  logic            empty;

  keypad_col_scan #(
    .NCOLS    (NCOLS),
    .NROWS    (NROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .row        (row),
    .col        (col),
    .frame_done (frame_done),
    .count      (frame_count),
    .code       (frame_code)
  );

  assign frame_cnt_e = contact_cnt_t'(frame_count);
  assign single      = (frame_cnt_e == ONE);
  assign empty       = (frame_cnt_e == NONE);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      state  <= IDLE;
      db_cnt <= '0;
      cand   <= '0;
    end else begin
      state  <= state_next;
      db_cnt <= db_next;
      cand   <= cand_next;
    end
  end

  // Debounce counts whole frames; a single qualifying frame suffices when DEBOUNCE is 1.
  always_comb begin
    state_next = state;
    db_next    = db_cnt;
    cand_next  = cand;
    accept     = 1'b0;
    if (frame_done) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            if (DEBOUNCE == 1) begin
              accept     = 1'b1;
              state_next = HELD;
            end else begin
              state_next = PRESS_DB;
              db_next    = DBW'(1);
              cand_next  = frame_code;
            end
          end
        end
        PRESS_DB: begin
          if (single && (frame_code == cand)) begin
            if (db_cnt == DBW'(DEBOUNCE - 1)) begin
              accept     = 1'b1;
              state_next = HELD;
              db_next    = '0;
            end else begin
              db_next = db_cnt + DBW'(1);
            end
          end else begin
            state_next = IDLE;
            db_next    = '0;
          end
        end
        HELD: begin
          if (empty) begin
            if (DEBOUNCE == 1) begin
              state_next = IDLE;
            end else begin
              state_next = REL_DB;
              db_next    = DBW'(1);
            end
          end
        end
        REL_DB: begin
          if (empty) begin
            if (db_cnt == DBW'(DEBOUNCE - 1)) begin
              state_next = IDLE;
              db_next    = '0;
            end else begin
              db_next = db_cnt + DBW'(1);
            end
          end else begin
            state_next = HELD;
            db_next    = '0;
          end
        end
        default: begin
          state_next = IDLE;
          db_next    = '0;
        end
      endcase
    end
  end

  // An ack in the accept cycle frees the slot, so the new key loads without overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      multi     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      multi   <= frame_done && (frame_cnt_e == MANY);
      overrun <= 1'b0;
      if (accept && key_valid && !key_ack) begin
        overrun <= 1'b1;
      end else if (accept) begin
        key_code  <= frame_code;
        key_valid <= 1'b1;
      end else if (key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
